control_unit_gen2: RTL and testbench

//  Parametrised next-generation FSM sequencer for the 8-bit accumulator CPU.

---
 rtl/control_unit_gen2_if.sv | 42 ++++
 rtl/control_unit_gen2.sv | 148 ++++++++++++++
 tb/tb_control_unit_gen2.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/control_unit_gen2_if.sv
// Control-unit <-> datapath signal bundle for the 8-bit accumulator CPU.
// mem_ready exists only when CU_MEM_WAIT_EN is defined.
interface control_unit_gen2_if #(
    parameter int OPC_W     = 8,
    parameter int ALU_SEL_W = 3
);
    logic [OPC_W-1:0]     IR;
    logic [3:0]           CCR_Result;
`ifdef CU_MEM_WAIT_EN
    logic                 mem_ready;
`endif
    logic                 IR_Load, MAR_Load, PC_Load, PC_Inc;
    logic                 A_Load, B_Load, CCR_Load;
    logic [ALU_SEL_W-1:0] ALU_Sel;
    logic [1:0]           Bus1_Sel, Bus2_Sel;
    logic                 write, halted, illegal_op;
    logic [4:0]           state_dbg;

`ifdef CU_MEM_WAIT_EN
    modport master (
        input  IR, CCR_Result, mem_ready,
        output IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
               ALU_Sel, Bus1_Sel, Bus2_Sel, write, halted, illegal_op, state_dbg
    );
    modport slave (
        output IR, CCR_Result, mem_ready,
        input  IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
               ALU_Sel, Bus1_Sel, Bus2_Sel, write, halted, illegal_op, state_dbg
    );
`else
    modport master (
        input  IR, CCR_Result,
        output IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
               ALU_Sel, Bus1_Sel, Bus2_Sel, write, halted, illegal_op, state_dbg
    );
    modport slave (
        output IR, CCR_Result,
        input  IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
               ALU_Sel, Bus1_Sel, Bus2_Sel, write, halted, illegal_op, state_dbg
    );
`endif
endinterface

// File: rtl/control_unit_gen2.sv
// Moore FSM sequencer for the 8-bit accumulator CPU (fetch/decode/execute, HLT, illegal trap).
// Define CU_MEM_WAIT_EN to stall memory-access states on mem_ready.
module control_unit_gen2 #(
    parameter int OPC_W        = 8,
    parameter int ALU_SEL_W    = 3,
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input logic                 Clk,
    input logic                 Reset,
    control_unit_gen2_if.master cu
);
    typedef enum logic [4:0] {
        S_FETCH0 = 5'd0, S_FETCH1, S_FETCH2, S_DECODE,
        S_MARPC, S_PCINC, S_LDMEM, S_MARMEM, S_IDLE, S_STWR,
        S_ALU, S_BRIDLE, S_BRLD, S_SKIP, S_HALT
    } state_e;

    state_e     state_q, state_d, dec_next;
    logic [7:0] ir_q, ir_d, opc;
    logic       ill_q, ill_d;
    logic       ready, hi_ok, br_taken, dec_legal;

`ifdef CU_MEM_WAIT_EN
    assign ready = cu.mem_ready;
`else
    assign ready = 1'b1;
`endif

    assign opc = cu.IR[7:0];
    if (OPC_W > 8) begin : g_wide
        assign hi_ok = ~|cu.IR[OPC_W-1:8];
    end else begin : g_narrow
        assign hi_ok = 1'b1;
    end

    // Condition flags are {N,Z,V,C}; odd low nibble tests flag set, even tests clear.
    always_comb begin
        case (opc[3:0])
            4'h1:    br_taken =  cu.CCR_Result[3];
            4'h2:    br_taken = ~cu.CCR_Result[3];
            4'h3:    br_taken =  cu.CCR_Result[2];
            4'h4:    br_taken = ~cu.CCR_Result[2];
            4'h5:    br_taken =  cu.CCR_Result[1];
            4'h6:    br_taken = ~cu.CCR_Result[1];
            4'h7:    br_taken =  cu.CCR_Result[0];
            4'h8:    br_taken = ~cu.CCR_Result[0];
            default: br_taken = 1'b1;
        endcase
    end

    always_comb begin
        dec_next  = S_FETCH0;
        dec_legal = hi_ok;
        case (opc) inside
            8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97, 8'h20: dec_next = S_MARPC;
            [8'h42:8'h49]: dec_next = S_ALU;
            [8'h21:8'h28]: dec_next = br_taken ? S_MARPC : S_SKIP;
            8'hFF:         dec_next = S_HALT;
            default:       dec_legal = 1'b0;
        endcase
        if (!dec_legal) dec_next = ILLEGAL_HALT ? S_HALT : S_FETCH0;
    end

    // ir_q holds the opcode latched in DECODE so shared execute states know the variant.
    always_comb begin
        state_d = state_q;
        ir_d    = (state_q == S_DECODE) ? opc : ir_q;
        ill_d   = ill_q | ((state_q == S_DECODE) && !dec_legal);
        case (state_q)
            S_FETCH0: state_d = S_FETCH1;
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: if (ready) state_d = S_DECODE;
            S_DECODE: state_d = dec_next;
            S_MARPC:  state_d = (ir_q[7:4] == 4'h2) ? S_BRIDLE : S_PCINC;
            S_PCINC:  state_d = (ir_q == 8'h86 || ir_q == 8'h88) ? S_LDMEM : S_MARMEM;
            S_MARMEM: if (ready) state_d = S_IDLE;
            S_IDLE:   state_d = (ir_q[7:4] == 4'h9) ? S_STWR : S_LDMEM;
            S_LDMEM, S_STWR, S_BRLD: if (ready) state_d = S_FETCH0;
            S_BRIDLE: state_d = S_BRLD;
            S_ALU, S_SKIP: state_d = S_FETCH0;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH0;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_FETCH0;
            ir_q    <= 8'h00;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ill_q   <= ill_d;
        end
    end

    always_comb begin
        cu.IR_Load  = 1'b0;
        cu.MAR_Load = 1'b0;
        cu.PC_Load  = 1'b0;
        cu.PC_Inc   = 1'b0;
        cu.A_Load   = 1'b0;
        cu.B_Load   = 1'b0;
        cu.CCR_Load = 1'b0;
        cu.ALU_Sel  = '0;
        cu.Bus1_Sel = 2'b00;
        cu.Bus2_Sel = 2'b01;
        cu.write    = 1'b0;
        case (state_q)
            S_FETCH0, S_MARPC: cu.MAR_Load = 1'b1;
            S_FETCH1, S_PCINC, S_SKIP: cu.PC_Inc = 1'b1;
            S_FETCH2: begin cu.IR_Load = 1'b1; cu.Bus2_Sel = 2'b10; end
            S_MARMEM: begin cu.MAR_Load = 1'b1; cu.Bus2_Sel = 2'b10; end
            S_BRLD:   begin cu.PC_Load = 1'b1; cu.Bus2_Sel = 2'b10; end
            S_LDMEM: begin
                cu.Bus2_Sel = 2'b10;
                if (ir_q == 8'h86 || ir_q == 8'h87) cu.A_Load = 1'b1;
                else                                 cu.B_Load = 1'b1;
            end
            S_STWR: begin
                cu.write    = 1'b1;
                cu.Bus1_Sel = (ir_q == 8'h96) ? 2'b01 : 2'b10;
            end
            S_ALU: begin
                cu.Bus2_Sel = 2'b00;
                cu.CCR_Load = 1'b1;
                case (ir_q)
                    8'h46: begin cu.Bus1_Sel = 2'b01; cu.ALU_Sel = ALU_SEL_W'(3'b100); cu.A_Load = 1'b1; end
                    8'h47: begin cu.Bus1_Sel = 2'b10; cu.ALU_Sel = ALU_SEL_W'(3'b100); cu.B_Load = 1'b1; end
                    8'h48: begin cu.Bus1_Sel = 2'b01; cu.ALU_Sel = ALU_SEL_W'(3'b101); cu.A_Load = 1'b1; end
                    8'h49: begin cu.Bus1_Sel = 2'b10; cu.ALU_Sel = ALU_SEL_W'(3'b101); cu.B_Load = 1'b1; end
                    // 0x42..0x45 map onto ALU ADD/SUB/AND/OR in order
                    default: begin
                        cu.Bus1_Sel = 2'b10;
                        cu.ALU_Sel  = ALU_SEL_W'(ir_q[2:0] - 3'd2);
                        cu.A_Load   = 1'b1;
                    end
                endcase
            end
            default: ;
        endcase
    end

    assign cu.halted     = (state_q == S_HALT);
    assign cu.illegal_op = ill_q;
    assign cu.state_dbg  = state_q;
endmodule

// File: tb/tb_control_unit_gen2.sv
// Directed table-driven bench for control_unit_gen2 plus hand sequences for reset/stall corners.
module tb_control_unit_gen2;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    control_unit_gen2_if #(.OPC_W(8), .ALU_SEL_W(3)) bus ();
    control_unit_gen2 dut (.Clk(clk), .Reset(rst), .cu(bus));

    localparam logic [6:0] L_IR  = 7'b1000000;
    localparam logic [6:0] L_MAR = 7'b0100000;
    localparam logic [6:0] L_PCL = 7'b0010000;
    localparam logic [6:0] L_PCI = 7'b0001000;
    localparam logic [6:0] L_A   = 7'b0000100;
    localparam logic [6:0] L_B   = 7'b0000010;
    localparam logic [6:0] L_CCR = 7'b0000001;

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [3:0]  ccr;
        int          c1;
        logic [15:0] e1;
        int          c2;
        logic [15:0] e2;
        logic        ill;
    } vec_t;

    vec_t vecs[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // {IR,MAR,PCL,PCI,A,B,CCR loads, ALU_Sel, Bus1, Bus2, write, halted}
    function automatic logic [15:0] o(input logic [6:0] ld, input logic [2:0] alu,
                                      input logic [1:0] b1, input logic [1:0] b2,
                                      input logic wr, input logic h);
        return {ld, alu, b1, b2, wr, h};
    endfunction

    function automatic logic [15:0] outs();
        return {bus.IR_Load, bus.MAR_Load, bus.PC_Load, bus.PC_Inc, bus.A_Load, bus.B_Load,
                bus.CCR_Load, bus.ALU_Sel, bus.Bus1_Sel, bus.Bus2_Sel, bus.write, bus.halted};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic [7:0] op, input logic [3:0] ccr,
                       input int c1, input logic [15:0] e1, input int c2,
                       input logic [15:0] e2, input logic ill);
        vecs.push_back('{nm, op, ccr, c1, e1, c2, e2, ill});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [15:0] F0, FE2, IDL, PCI, PCL, HLT;
    int wcnt, icnt;

    initial begin
        bus.IR = 8'h00;
        bus.CCR_Result = 4'h0;
`ifdef CU_MEM_WAIT_EN
        bus.mem_ready = 1'b1;
`endif
        F0  = o(L_MAR, 3'd0, 2'd0, 2'd1, 1'b0, 1'b0);
        FE2 = o(L_IR,  3'd0, 2'd0, 2'd2, 1'b0, 1'b0);
        IDL = o(7'd0,  3'd0, 2'd0, 2'd1, 1'b0, 1'b0);
        PCI = o(L_PCI, 3'd0, 2'd0, 2'd1, 1'b0, 1'b0);
        PCL = o(L_PCL, 3'd0, 2'd0, 2'd2, 1'b0, 1'b0);
        HLT = o(7'd0,  3'd0, 2'd0, 2'd1, 1'b0, 1'b1);

        add("lda_imm", 8'h86, 4'h0, 7, o(L_A, 3'd0, 2'd0, 2'd2, 1'b0, 1'b0), 10, FE2, 1'b0);
        add("ldb_imm", 8'h88, 4'h0, 7, o(L_B, 3'd0, 2'd0, 2'd2, 1'b0, 1'b0), 10, FE2, 1'b0);
        add("lda_dir", 8'h87, 4'h0, 9, o(L_A, 3'd0, 2'd0, 2'd2, 1'b0, 1'b0), 12, FE2, 1'b0);
        add("ldb_dir", 8'h89, 4'h0, 7, o(L_MAR, 3'd0, 2'd0, 2'd2, 1'b0, 1'b0), 12, FE2, 1'b0);
        add("sta_dir", 8'h96, 4'h0, 9, o(7'd0, 3'd0, 2'd1, 2'd1, 1'b1, 1'b0), 12, FE2, 1'b0);
        add("stb_dir", 8'h97, 4'h0, 9, o(7'd0, 3'd0, 2'd2, 2'd1, 1'b1, 1'b0), 12, FE2, 1'b0);
        add("add_ab",  8'h42, 4'h0, 5, o(L_A | L_CCR, 3'd0, 2'd2, 2'd0, 1'b0, 1'b0), 8, FE2, 1'b0);
        add("sub_ab",  8'h43, 4'h0, 5, o(L_A | L_CCR, 3'd1, 2'd2, 2'd0, 1'b0, 1'b0), 8, FE2, 1'b0);
        add("and_ab",  8'h44, 4'h0, 5, o(L_A | L_CCR, 3'd2, 2'd2, 2'd0, 1'b0, 1'b0), 8, FE2, 1'b0);
        add("or_ab",   8'h45, 4'h0, 5, o(L_A | L_CCR, 3'd3, 2'd2, 2'd0, 1'b0, 1'b0), 8, FE2, 1'b0);
        add("inca",    8'h46, 4'h0, 5, o(L_A | L_CCR, 3'd4, 2'd1, 2'd0, 1'b0, 1'b0), 8, FE2, 1'b0);
        add("incb",    8'h47, 4'h0, 5, o(L_B | L_CCR, 3'd4, 2'd2, 2'd0, 1'b0, 1'b0), 8, FE2, 1'b0);
        add("deca",    8'h48, 4'h0, 5, o(L_A | L_CCR, 3'd5, 2'd1, 2'd0, 1'b0, 1'b0), 8, FE2, 1'b0);
        add("decb",    8'h49, 4'h0, 5, o(L_B | L_CCR, 3'd5, 2'd2, 2'd0, 1'b0, 1'b0), 8, FE2, 1'b0);
        add("bra",     8'h20, 4'h0, 7, PCL, 10, FE2, 1'b0);
        add("bra_idle",8'h20, 4'h0, 6, IDL, 10, FE2, 1'b0);
        add("beq_t",   8'h23, 4'b0100, 7, PCL, 10, FE2, 1'b0);
        add("beq_nt",  8'h23, 4'b1011, 5, PCI, 8, FE2, 1'b0);
        add("bmi_t",   8'h21, 4'b1000, 7, PCL, 10, FE2, 1'b0);
        add("bpl_nt",  8'h22, 4'b1000, 5, PCI, 8, FE2, 1'b0);
        add("bne_t",   8'h24, 4'b0000, 7, PCL, 10, FE2, 1'b0);
        add("bvs_t",   8'h25, 4'b0010, 7, PCL, 10, FE2, 1'b0);
        add("bvc_nt",  8'h26, 4'b0010, 5, PCI, 8, FE2, 1'b0);
        add("bcs_t",   8'h27, 4'b0001, 7, PCL, 10, FE2, 1'b0);
        add("bcc_nt",  8'h28, 4'b0001, 5, PCI, 8, FE2, 1'b0);
        add("hlt",     8'hFF, 4'h0, 5, HLT, 9, HLT, 1'b0);
        add("illegal", 8'h33, 4'h0, 5, HLT, 9, HLT, 1'b1);

        // reset state, checked before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("reset_outs", outs(), F0);
        chk("reset_state", 16'(bus.state_dbg), 16'd0);
        chk("reset_illegal", 16'(bus.illegal_op), 16'd0);

        foreach (vecs[i]) begin
            bus.IR = vecs[i].op;
            bus.CCR_Result = vecs[i].ccr;
            do_reset();
            for (int c = 1; c <= vecs[i].c2; c++) begin
                if (c == vecs[i].c1) chk({vecs[i].name, "_c1"}, outs(), vecs[i].e1);
                if (c == vecs[i].c2) begin
                    chk({vecs[i].name, "_c2"}, outs(), vecs[i].e2);
                    chk({vecs[i].name, "_ill"}, 16'(bus.illegal_op), 16'(vecs[i].ill));
                end
                if (c < vecs[i].c2) @(negedge clk);
            end
        end

        // leaving HALT after the illegal trap: asynchronous reset clears both flags
        rst = 1'b1;
        #1;
        chk("illreset_halted", 16'(bus.halted), 16'd0);
        chk("illreset_illegal", 16'(bus.illegal_op), 16'd0);
        chk("illreset_outs", outs(), F0);
        @(negedge clk);
        rst = 1'b0;

        // STA: write exactly one cycle (cycle 9), then FETCH0
        bus.IR = 8'h96;
        do_reset();
        wcnt = 0;
        for (int c = 1; c <= 10; c++) begin
            if (bus.write) wcnt++;
            if (c == 10) chk("sta_then_fetch0", outs(), F0);
            if (c < 10) @(negedge clk);
        end
        chk("sta_write_cycles", 16'(wcnt), 16'd1);

        // reset during the write cycle drops write with no clock edge
        do_reset();
        for (int c = 1; c < 9; c++) @(negedge clk);
        chk("sta_mid_write", 16'(bus.write), 16'd1);
        #2 rst = 1'b1;
        #1;
        chk("reset_mid_write", outs(), F0);
        @(negedge clk);
        rst = 1'b0;

`ifdef CU_MEM_WAIT_EN
        // mem_ready low for 3 cycles in FETCH2 stretches IR_Load to 4 cycles
        bus.IR = 8'h86;
        do_reset();
        icnt = 0;
        for (int c = 1; c <= 7; c++) begin
            if (c == 3) bus.mem_ready = 1'b0;
            if (c == 6) bus.mem_ready = 1'b1;
            if (bus.IR_Load) icnt++;
            if (c == 7) chk("wait_decode", outs(), IDL);
            if (c < 7) @(negedge clk);
        end
        chk("wait_irload_cycles", 16'(icnt), 16'd4);
`else
        icnt = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
